// File: rtl/peripheral_root_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : peripheral_root_controller_if                              |
// | Description : Bus bundle between the peripheral root controller, the    |
// |               peripheral enable tree below it and the shared             |
// |               clock/power source it sequences.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Signals:
//   tree_request      OR of all child parent_request lines (tree -> root)
//   tree_ready        source running and settled; children may enable
//   tree_silent       tree fully off
//   tree_starting     root powering up the source
//   tree_stopping     children must drop enables
//   source_enable_req request to the clock/power source (root -> source)
//   source_enable_ack source acknowledge (source -> root)
//   source_fault      one-cycle pulse when the source ack is lost
// Modports:
//   master  the root controller
//   slave   the tree / source environment
interface peripheral_root_controller_if;
  logic tree_request;
  logic tree_ready;
  logic tree_silent;
  logic tree_starting;
  logic tree_stopping;
  logic source_enable_req;
  logic source_enable_ack;
  logic source_fault;

  modport master (
    input  tree_request,
    input  source_enable_ack,
    output tree_ready,
    output tree_silent,
    output tree_starting,
    output tree_stopping,
    output source_enable_req,
    output source_fault
  );

  modport slave (
    output tree_request,
    output source_enable_ack,
    input  tree_ready,
    input  tree_silent,
    input  tree_starting,
    input  tree_stopping,
    input  source_enable_req,
    input  source_fault
  );
endinterface
`default_nettype wire

// File: rtl/peripheral_root_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : peripheral_root_controller                                 |
// | Description : Root node of the peripheral enable tree. Sequences a      |
// |               shared clock/power source through an enable req/ack       |
// |               handshake, waits a settle delay after ack, tolerates a    |
// |               short idle hold-off, then drains the tree and shuts the    |
// |               source down.                                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Parameters:
//   SETTLE_CYCLES  cycles spent settling after ack rises (0 skips settling)
//   IDLE_CYCLES    cycles of absent request tolerated before draining
//                  (0 drains immediately)
//   COUNTER_WIDTH  width of the shared down-counter; both delays must fit
// Ports:
//   clock         single clock, rising edge
//   async_resetn  asynchronous active-low reset
//   bus           master side of peripheral_root_controller_if
module peripheral_root_controller #(
  parameter int SETTLE_CYCLES = 16,
  parameter int IDLE_CYCLES   = 8,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          async_resetn,
  peripheral_root_controller_if.master  bus
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAKE     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_READY    = 3'd3,
    ST_HOLD     = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_SHUTDOWN = 3'd6
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] c_settle_load = COUNTER_WIDTH'(SETTLE_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] c_idle_load   = COUNTER_WIDTH'(IDLE_CYCLES);
  // Two quiet cycles cover the children's one-cycle enable delay.
  localparam logic [COUNTER_WIDTH-1:0] c_drain_load  = COUNTER_WIDTH'(2);
  localparam logic [COUNTER_WIDTH-1:0] c_one         = COUNTER_WIDTH'(1);
  localparam bit                       c_skip_settle = (SETTLE_CYCLES == 0);
  localparam bit                       c_skip_hold   = (IDLE_CYCLES == 0);

  state_t                     state_q, state_d;
  logic [COUNTER_WIDTH-1:0]   cnt_q,   cnt_d;
  logic                       fault_q, fault_d;

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (bus.tree_request) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (bus.source_enable_ack) begin
          if (c_skip_settle) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = c_settle_load;
          end
        end
      end
      // In SETTLE/READY/HOLD the source has already acknowledged, so a low
      // ack means it was lost; that outranks every other transition.
      ST_SETTLE: begin
        if (!bus.source_enable_ack) begin
          state_d = ST_WAKE;
          fault_d = 1'b1;
        end else if (cnt_q == c_one) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - c_one;
        end
      end
      ST_READY: begin
        if (!bus.source_enable_ack) begin
          state_d = ST_WAKE;
          fault_d = 1'b1;
        end else if (!bus.tree_request) begin
          if (c_skip_hold) begin
            state_d = ST_DRAIN;
            cnt_d   = c_drain_load;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = c_idle_load;
          end
        end
      end
      ST_HOLD: begin
        if (!bus.source_enable_ack) begin
          state_d = ST_WAKE;
          fault_d = 1'b1;
        end else if (bus.tree_request) begin
          state_d = ST_READY;
        end else if (cnt_q == c_one) begin
          state_d = ST_DRAIN;
          cnt_d   = c_drain_load;
        end else begin
          cnt_d = cnt_q - c_one;
        end
      end
      ST_DRAIN: begin
        // Any request restarts the quiet window; it never aborts the drain.
        if (bus.tree_request) begin
          cnt_d = c_drain_load;
        end else if (cnt_q == c_one) begin
          state_d = ST_SHUTDOWN;
        end else begin
          cnt_d = cnt_q - c_one;
        end
      end
      ST_SHUTDOWN: begin
        if (!bus.source_enable_ack) state_d = ST_OFF;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  assign bus.tree_silent       = (state_q == ST_OFF);
  assign bus.tree_starting     = (state_q == ST_WAKE)  || (state_q == ST_SETTLE);
  assign bus.tree_ready        = (state_q == ST_READY) || (state_q == ST_HOLD);
  assign bus.tree_stopping     = (state_q == ST_DRAIN) || (state_q == ST_SHUTDOWN);
  assign bus.source_enable_req = (state_q != ST_OFF)   && (state_q != ST_SHUTDOWN);
  assign bus.source_fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_root_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_peripheral_root_controller                              |
// | Description : Self-checking bench for peripheral_root_controller. Two    |
// |               instances (16/8 and 0/0 delays) are compared every cycle  |
// |               against a phase/elapsed-time model, with directed         |
// |               scenarios pinned by hand-computed expectations and a      |
// |               randomized source/tree environment.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_peripheral_root_controller;

  localparam int S_A = 16;
  localparam int I_A = 8;
  localparam int S_B = 0;
  localparam int I_B = 0;

  logic clock = 1'b0;
  logic rstn;
  logic req_in [2];
  logic ack_in [2];

  always #5 clock = ~clock;

  peripheral_root_controller_if ifa ();
  peripheral_root_controller_if ifb ();

  assign ifa.tree_request      = req_in[0];
  assign ifa.source_enable_ack = ack_in[0];
  assign ifb.tree_request      = req_in[1];
  assign ifb.source_enable_ack = ack_in[1];

  peripheral_root_controller #(.SETTLE_CYCLES(S_A), .IDLE_CYCLES(I_A), .COUNTER_WIDTH(8)) dut_a (
    .clock        (clock),
    .async_resetn (rstn),
    .bus          (ifa)
  );

  peripheral_root_controller #(.SETTLE_CYCLES(S_B), .IDLE_CYCLES(I_B), .COUNTER_WIDTH(8)) dut_b (
    .clock        (clock),
    .async_resetn (rstn),
    .bus          (ifb)
  );

  // {silent, starting, ready, stopping, req, fault}
  logic [5:0] got_a, got_b;
  assign got_a = {ifa.tree_silent, ifa.tree_starting, ifa.tree_ready,
                  ifa.tree_stopping, ifa.source_enable_req, ifa.source_fault};
  assign got_b = {ifb.tree_silent, ifb.tree_starting, ifb.tree_ready,
                  ifb.tree_stopping, ifb.source_enable_req, ifb.source_fault};

  // Reference model: named phase plus elapsed cycles within it.
  typedef enum logic [2:0] {P_OFF, P_WAKE, P_SETTLE, P_READY, P_HOLD, P_DRAIN, P_SHUT} phase_t;
  typedef struct packed {
    phase_t ph;
    int     t;
    logic   f;
  } mstate_t;

  localparam mstate_t M_RESET = '{ph: P_OFF, t: 0, f: 1'b0};
  mstate_t m [2];

  function automatic mstate_t model_next(mstate_t s, logic rq, logic ak, int sc, int ic);
    mstate_t n;
    n   = s;
    n.f = 1'b0;
    case (s.ph)
      P_OFF:    if (rq) n.ph = P_WAKE;
      P_WAKE:   if (ak) begin n.t = 0; n.ph = (sc == 0) ? P_READY : P_SETTLE; end
      P_SETTLE: if (!ak) begin n.ph = P_WAKE; n.f = 1'b1; end
                else begin n.t = s.t + 1; if (n.t >= sc) n.ph = P_READY; end
      P_READY:  if (!ak) begin n.ph = P_WAKE; n.f = 1'b1; end
                else if (!rq) begin n.t = 0; n.ph = (ic == 0) ? P_DRAIN : P_HOLD; end
      P_HOLD:   if (!ak) begin n.ph = P_WAKE; n.f = 1'b1; end
                else if (rq) n.ph = P_READY;
                else begin
                  n.t = s.t + 1;
                  if (n.t >= ic) begin n.ph = P_DRAIN; n.t = 0; end
                end
      P_DRAIN:  begin n.t = rq ? 0 : s.t + 1; if (n.t >= 2) n.ph = P_SHUT; end
      P_SHUT:   if (!ak) n.ph = P_OFF;
      default:  n.ph = P_OFF;
    endcase
    return n;
  endfunction

  function automatic logic [5:0] model_out(mstate_t s);
    logic sil, stg, rdy, stp, rq;
    sil = (s.ph == P_OFF);
    stg = (s.ph == P_WAKE) || (s.ph == P_SETTLE);
    rdy = (s.ph == P_READY) || (s.ph == P_HOLD);
    stp = (s.ph == P_DRAIN) || (s.ph == P_SHUT);
    rq  = !sil && (s.ph != P_SHUT);
    return {sil, stg, rdy, stp, rq, s.f};
  endfunction

  always @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      m[0] <= M_RESET;
      m[1] <= M_RESET;
    end else begin
      m[0] <= model_next(m[0], req_in[0], ack_in[0], S_A, I_A);
      m[1] <= model_next(m[1], req_in[1], ack_in[1], S_B, I_B);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // One cycle: advance to the falling edge and compare both DUTs to the model.
  task automatic tick();
    @(negedge clock);
    check("model_a", 32'(got_a), 32'(model_out(m[0])));
    check("model_b", 32'(got_b), 32'(model_out(m[1])));
  endtask

  task automatic drive_rand(input int i, input logic req_out);
    if ($urandom_range(0, 99) < 8) req_in[i] = ~req_in[i];
    if (ack_in[i] != req_out) begin
      if ($urandom_range(0, 2) == 0) ack_in[i] = req_out;
    end else if (ack_in[i] && $urandom_range(0, 99) < 2) begin
      ack_in[i] = 1'b0;
    end
  endtask

  initial begin
    int st, rc, dc, sc;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin req_in[i] = 1'b0; ack_in[i] = 1'b0; end
    @(negedge clock);
    @(negedge clock);
    rstn = 1'b1;

    // Reset state, held idle for 20 cycles.
    for (int k = 0; k < 20; k++) tick();
    check("idle_a_outputs", 32'(got_a), 32'b100000);
    check("idle_b_outputs", 32'(got_b), 32'b100000);

    // Full start-up with ack three cycles after req, then the stop path.
    req_in[0] = 1'b1;
    st = 0;
    for (int k = 0; k < 60 && !ifa.tree_ready; k++) begin
      tick();
      if (ifa.tree_starting) st++;
      if (st == 3) ack_in[0] = 1'b1;
    end
    check("startup_cycles", 32'(st), 32'd19);
    check("ready_after_settle", 32'(ifa.tree_ready), 32'd1);

    req_in[0] = 1'b0;
    rc = 0;
    for (int k = 0; k < 40 && !ifa.tree_stopping; k++) begin
      tick();
      if (ifa.tree_ready) rc++;
    end
    check("hold_ready_cycles", 32'(rc), 32'd8);
    dc = 1;
    for (int k = 0; k < 20 && ifa.tree_stopping && ifa.source_enable_req; k++) begin
      tick();
      if (ifa.tree_stopping && ifa.source_enable_req) dc++;
    end
    check("drain_cycles", 32'(dc), 32'd2);
    check("shutdown_state", 32'({ifa.tree_stopping, ifa.source_enable_req}), 32'b10);
    tick();
    tick();
    check("shutdown_waits_ack", 32'(ifa.tree_stopping), 32'd1);
    ack_in[0] = 1'b0;
    tick();
    check("silent_after_ack_low", 32'(got_a), 32'b100000);

    // Short request gap inside the hold-off never reaches the drain.
    req_in[0] = 1'b1;
    ack_in[0] = 1'b1;
    for (int k = 0; k < 40 && !ifa.tree_ready; k++) tick();
    check("ready_again", 32'(ifa.tree_ready), 32'd1);
    req_in[0] = 1'b0;
    rc = 0;
    sc = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (ifa.tree_ready) rc++;
      if (ifa.tree_stopping) sc++;
      if (i == 4) req_in[0] = 1'b1;
    end
    check("gap_ready_cycles", 32'(rc), 32'd13);
    check("gap_stopping_cycles", 32'(sc), 32'd0);

    // Request re-asserted during SHUTDOWN completes to OFF, then wakes.
    req_in[0] = 1'b0;
    for (int k = 0; k < 30 && !(ifa.tree_stopping && !ifa.source_enable_req); k++) tick();
    req_in[0] = 1'b1;
    tick();
    tick();
    check("shutdown_not_aborted", 32'({ifa.tree_stopping, ifa.source_enable_req}), 32'b10);
    ack_in[0] = 1'b0;
    tick();
    check("off_one_cycle", 32'(got_a), 32'b100000);
    tick();
    check("rewake", 32'(got_a), 32'b010010);
    ack_in[0] = 1'b1;
    for (int k = 0; k < 40 && !ifa.tree_ready; k++) tick();
    check("ready_after_rewake", 32'(ifa.tree_ready), 32'd1);

    // Single-cycle ack loss in READY.
    ack_in[0] = 1'b0;
    tick();
    check("fault_pulse", 32'(got_a), 32'b010011);
    ack_in[0] = 1'b1;
    tick();
    check("fault_one_cycle", 32'(got_a), 32'b010010);
    for (int k = 0; k < 40 && !ifa.tree_ready; k++) tick();
    check("ready_after_fault", 32'(ifa.tree_ready), 32'd1);

    // Reset mid-operation drops req immediately.
    @(posedge clock);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_req_drop", 32'(ifa.source_enable_req), 32'd0);
    check("rst_silent", 32'(ifa.tree_silent), 32'd1);
    req_in[0] = 1'b0;
    ack_in[0] = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Zero settle / zero idle instance.
    req_in[1] = 1'b1;
    tick();
    tick();
    ack_in[1] = 1'b1;
    tick();
    check("b_ready_after_ack", 32'(got_b), 32'b001010);
    req_in[1] = 1'b0;
    tick();
    check("b_drain_direct", 32'(got_b), 32'b000110);
    dc = 1;
    for (int k = 0; k < 20 && ifb.tree_stopping && ifb.source_enable_req; k++) begin
      tick();
      if (ifb.tree_stopping && ifb.source_enable_req) dc++;
    end
    check("b_drain_cycles", 32'(dc), 32'd2);
    ack_in[1] = 1'b0;
    tick();
    check("b_silent", 32'(got_b), 32'b100000);

    // Randomized tree/source behaviour, checked cycle by cycle.
    for (int c = 0; c < 3000; c++) begin
      tick();
      drive_rand(0, ifa.source_enable_req);
      drive_rand(1, ifb.source_enable_req);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/peripheral_root_controller.md
# peripheral_root_controller

Root node of the peripheral enable tree. It takes the OR-ed request coming up from the peripheral control nodes and drives the downward ready/silent/starting/stopping status. It sequences a shared clock/power source through its own enable_req/enable_ack handshake, with a settle delay after the source acknowledges and an idle hold-off before the tree is drained and shut down.

## Interface
- SETTLE_CYCLES, default 16: cycles spent in SETTLE after source ack rises; 0 skips SETTLE.
- IDLE_CYCLES, default 8: cycles of absent request tolerated in HOLD before DRAIN; 0 skips HOLD.
- COUNTER_WIDTH, default 8: width of the shared down-counter; SETTLE_CYCLES and IDLE_CYCLES must fit.

Ports:
- clock  input  1  single clock, rising edge.
- async_resetn  input  1  asynchronous, active-low reset.
- tree_request  input  1  OR of all child parent_request lines.
- tree_ready  output  1  source running and settled; children may enable.
- tree_silent  output  1  tree fully off.
- tree_starting  output  1  root powering up the source.
- tree_stopping  output  1  children must drop enables.
- source_enable_req  output  1  request to the clock/power source.
- source_enable_ack  input  1  source acknowledge; follows req with arbitrary latency.
- source_fault  output  1  one-cycle pulse when ack drops while req is held and ack was previously seen.

## Operation
- Moore FSM. All outputs are decoded from the registered state, except source_fault, which is a registered pulse. No combinational input-to-output paths.
- One shared down-counter. It is loaded on entry to SETTLE, HOLD and DRAIN.
- States and outputs (unlisted outputs are 0):
  - OFF: silent=1. tree_request=1 -> WAKE.
  - WAKE: starting=1, req=1. ack=1 -> SETTLE (or READY if SETTLE_CYCLES=0).
  - SETTLE: starting=1, req=1. Counter starts at SETTLE_CYCLES and decrements each cycle. Leave when it reaches 1 -> READY.
  - READY: ready=1, req=1. tree_request=0 -> HOLD (or DRAIN if IDLE_CYCLES=0).
  - HOLD: ready=1, req=1. tree_request=1 -> READY and the counter is discarded. Counter expiry (IDLE_CYCLES cycles) -> DRAIN.
  - DRAIN: stopping=1, req=1. The counter is loaded with 2 and restarts at 2 whenever tree_request=1. -> SHUTDOWN once tree_request has been 0 for 2 consecutive cycles, which covers the children's one-cycle enable delay.
  - SHUTDOWN: stopping=1, req=0. ack=0 -> OFF.
- Request drop during WAKE/SETTLE does not abort; startup completes, then READY -> HOLD.
- Request during DRAIN/SHUTDOWN does not abort; shutdown completes, then OFF -> WAKE on the next cycle if request is still high.
- Fault: ack=0 in SETTLE, READY or HOLD -> WAKE on the next edge and source_fault=1 for exactly that one cycle. req stays high. Fault has priority over every other transition from those states.
- Exactly one of silent/starting/ready/stopping is 1 in every state except WAKE/SETTLE (starting only) and DRAIN/SHUTDOWN (stopping only). ready and stopping are never both 1.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - State is OFF.
  - tree_silent=1. tree_ready, tree_starting, tree_stopping, source_enable_req and source_fault are 0.
  - Counter is 0.
  - Reset mid-operation forces OFF immediately and drops req in the same instant, regardless of ack.
- Latency, with T = first edge sampling tree_request=1 in OFF:
  - starting=1 and req=1 after edge T.
  - If ack rises at edge A, SETTLE occupies SETTLE_CYCLES cycles and ready=1 after edge A+SETTLE_CYCLES.
  - If SETTLE_CYCLES=0, ready=1 after edge A.
- Stop path: request low from edge R gives:
  - HOLD for IDLE_CYCLES cycles;
  - DRAIN for at least 2 cycles;
  - SHUTDOWN until ack=0;
  - silent=1 on the cycle after ack is sampled low.
- ack already 0 on SHUTDOWN entry gives a one-cycle SHUTDOWN.
- ack already 1 on WAKE entry gives a one-cycle WAKE.

## Test plan
- Reset with tree_request=0 -> silent=1, all other outputs 0. Hold for 20 cycles -> no change.
- SETTLE_CYCLES=16, ack 3 cycles after req -> starting for 3+16 cycles, then ready=1. Drop request -> ready stays for 8 HOLD cycles, stopping for 2 DRAIN cycles, SHUTDOWN, silent after ack=0.
- Request drops for 5 cycles in HOLD (IDLE_CYCLES=8), then returns -> stays ready, never stopping.
- Request re-asserted during SHUTDOWN -> completes to OFF for 1 cycle, then WAKE with req=1.
- ack forced low for 1 cycle in READY -> source_fault pulses once, state WAKE, ready=0, starting=1. ack returns -> SETTLE, then READY.
- SETTLE_CYCLES=0, IDLE_CYCLES=0 -> READY on the cycle after ack. Request drop gives DRAIN directly, with a minimum of 2 stopping cycles before SHUTDOWN.
